// File: rtl/acc_pkg.sv
// Shared constants for the offset accumulator: overflow modes and the default base value.
package acc_pkg;

  localparam int unsigned ACC_WRAP = 0;
  localparam int unsigned ACC_SAT  = 1;

  localparam logic [7:0] BASE_DEFAULT = 8'hAE;

endpackage

// File: rtl/sat_add.sv
// Combinational WIDTH+1 add of an accumulator and a zero-extended narrow sample,
// with optional clamp to all-ones when the add carries out.
module sat_add
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IN_W     = 2,
  parameter int unsigned SATURATE = ACC_WRAP
) (
  input  logic [WIDTH-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = {1'b0, a} + {{(WIDTH + 1 - IN_W){1'b0}}, b};
    carry   = sum_ext[WIDTH];
    if (carry && (SATURATE == ACC_SAT)) begin
      result = '1;
    end else begin
      result = sum_ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/offset_accumulator.sv
// Registered accumulator starting from BASE; adds accepted samples with wrap or
// saturate overflow handling and reports a sticky overflow and a saturating count.
module offset_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       IN_W     = 2,
  parameter logic [WIDTH-1:0]  BASE     = BASE_DEFAULT,
  parameter int unsigned       SATURATE = ACC_WRAP,
  parameter int unsigned       CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic [WIDTH-1:0] sum_out,
  output logic [WIDTH-1:0] base_out,
  output logic             out_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] base_q;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_result;
  logic             add_carry;

  sat_add #(
    .WIDTH    (WIDTH),
    .IN_W     (IN_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a      (sum_q),
    .b      (in_data),
    .result (add_result),
    .carry  (add_carry)
  );

  // Clear outranks an accept; a colliding sample is dropped entirely.
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      sum_d = BASE;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (in_valid) begin
      sum_d   = add_result;
      valid_d = 1'b1;
      ovf_d   = ovf_q | add_carry;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= BASE;
      base_q  <= BASE;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      base_q  <= BASE;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_out   = sum_q;
  assign base_out  = base_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign count     = cnt_q;

endmodule
